// File: rtl/gpio_pkg.sv
// gpio_pkg: shared defaults for the GPIO input conditioner (debounce enabled by GPIO_IN_DEBOUNCE_EN)
package gpio_pkg;
   localparam int GPIO_CHANNELS      = 4;
   localparam int GPIO_DEBOUNCE_BITS = 8;
`ifdef GPIO_IN_DEBOUNCE_EN
   localparam bit GPIO_DEBOUNCE_EN   = 1'b1;
`else
   localparam bit GPIO_DEBOUNCE_EN   = 1'b0;
`endif
endpackage

// File: rtl/gpio_debounce_channel.sv
// gpio_debounce_channel: sync, optional debounce (GPIO_IN_DEBOUNCE_EN), accepted level and edge pulses for one pin
module gpio_debounce_channel
   import gpio_pkg::*;
#(
   parameter int DEBOUNCE_BITS = GPIO_DEBOUNCE_BITS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_pin_raw,
   input  logic [DEBOUNCE_BITS-1:0] i_limit,
   input  logic                     i_rise_en,
   input  logic                     i_fall_en,
   output logic                     o_stable,
   output logic                     o_rise,
   output logic                     o_fall
);
   logic r_s1, r_s2, r_stable, r_rise, r_fall;
   logic w_accept;
   // two-flop synchroniser on the raw pad input
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {r_s2, r_s1} <= 2'b00;
      else        {r_s2, r_s1} <= {r_s1, i_pin_raw};
`ifdef GPIO_IN_DEBOUNCE_EN
   logic [DEBOUNCE_BITS-1:0] r_cnt;
   assign w_accept = (r_s2 != r_stable) && (r_cnt >= i_limit);
   // count while the synced level disagrees; any agreement or acceptance restarts it, and it stops at the limit
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_cnt <= '0;
      else        r_cnt <= (r_s2 == r_stable || w_accept) ? '0 : r_cnt + 1'b1;
`else
   logic w_unused;
   assign w_unused = ^i_limit;
   assign w_accept = r_s2 != r_stable;
`endif
   // accepted level plus registered edge pulses on the edge it changes
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_stable <= 1'b0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
      end else begin
         r_stable <= w_accept ? r_s2 : r_stable;
         r_rise   <= w_accept & r_s2 & i_rise_en;
         r_fall   <= w_accept & ~r_s2 & i_fall_en;
      end
   assign o_stable = r_stable;
   assign o_rise   = r_rise;
   assign o_fall   = r_fall;
endmodule

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: per-pin conditioning, sticky edge events and irq (debounce enabled by GPIO_IN_DEBOUNCE_EN)
module gpio_input_conditioner
   import gpio_pkg::*;
#(
   parameter int CHANNELS      = GPIO_CHANNELS,
   parameter int DEBOUNCE_BITS = GPIO_DEBOUNCE_BITS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CHANNELS-1:0]      pins_raw,
   output logic [CHANNELS-1:0]      pins_i,
   input  logic [DEBOUNCE_BITS-1:0] debounce_limit,
   input  logic [CHANNELS-1:0]      rise_en,
   input  logic [CHANNELS-1:0]      fall_en,
   input  logic [CHANNELS-1:0]      event_clr,
   output logic [CHANNELS-1:0]      events,
   output logic                     irq
);
   logic [CHANNELS-1:0] w_rise, w_fall, r_events;
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      gpio_debounce_channel #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_pin_raw (pins_raw[g]),
         .i_limit   (debounce_limit),
         .i_rise_en (rise_en[g]),
         .i_fall_en (fall_en[g]),
         .o_stable  (pins_i[g]),
         .o_rise    (w_rise[g]),
         .o_fall    (w_fall[g])
      );
   end
   // sticky events; a new edge beats a same-cycle clear
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_events <= '0;
      else        r_events <= (r_events & ~event_clr) | w_rise | w_fall;
   assign events = r_events;
   assign irq    = |r_events;
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb_gpio_input_conditioner: directed checks of sync latency, debounce, sticky events and async reset
module tb_gpio_input_conditioner;
`ifdef GPIO_IN_DEBOUNCE_EN
   localparam bit DEB = 1'b1;
`else
   localparam bit DEB = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] pins_raw = '0, pins_i, rise_en = '0, fall_en = '0, event_clr = '0, events;
   logic [7:0] debounce_limit = 8'd4;
   logic       irq;
   int         n_tests = 0, n_fail = 0;
   int         lat;

   gpio_input_conditioner dut (
      .clk(clk), .rst_n(rst_n), .pins_raw(pins_raw), .pins_i(pins_i),
      .debounce_limit(debounce_limit), .rise_en(rise_en), .fall_en(fall_en),
      .event_clr(event_clr), .events(events), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      lat = DEB ? 7 : 3;
      #2;
      chk("rst_pins", pins_i, 0);
      chk("rst_events", events, 0);
      chk("rst_irq", irq, 0);
      tick(2);
      rst_n = 1'b1;
      rise_en = 4'hF;
      fall_en = 4'hF;
      tick(3);
      // ch0 rise with L=4: level at edge lat, event one edge later
      pins_raw[0] = 1'b1;
      for (int e = 1; e <= lat; e++) begin
         tick(1);
         chk("t1_pin0", pins_i[0], e >= lat);
         chk("t1_ev0", events[0], 0);
      end
      tick(1);
      chk("t1_ev0_set", events, 4'b0001);
      chk("t1_irq", irq, 1);
      event_clr = 4'hF;
      tick(1);
      event_clr = '0;
      chk("clr_events", events, 0);
      chk("clr_irq", irq, 0);
      // ch1 three-cycle pulse
      pins_raw[1] = 1'b1;
      tick(3);
      pins_raw[1] = 1'b0;
      if (DEB) begin
         for (int e = 4; e <= 12; e++) begin
            tick(1);
            chk("t2_pin1_glitch", pins_i[1], 0);
         end
         chk("t2_ev1", events[1], 0);
      end else begin
         chk("t2_pin1_pass", pins_i[1], 1);
         tick(3);
         chk("t2_pin1_low", pins_i[1], 0);
         tick(1);
         chk("t2_ev1", events[1], 1);
      end
      event_clr = 4'hF;
      tick(1);
      event_clr = '0;
      chk("t2_clr", events, 0);
      // ch2: fall event coincides with clear, set wins
      pins_raw[2] = 1'b1;
      tick(lat + 1);
      chk("t3_ev2_rise", events, 4'b0100);
      pins_raw[2] = 1'b0;
      tick(lat);
      chk("t3_pin2_low", pins_i[2], 0);
      event_clr[2] = 1'b1;
      tick(1);
      event_clr = '0;
      chk("t3_set_wins", events[2], 1);
      event_clr[2] = 1'b1;
      tick(1);
      event_clr = '0;
      chk("t3_clr_only", events, 0);
      chk("t3_irq_low", irq, 0);
      // simultaneous fall on ch0 and rise on ch3
      pins_raw = 4'b1000;
      tick(lat + 1);
      chk("multi_events", events, 4'b1001);
      chk("multi_pins", pins_i, 4'b1000);
      // async reset part-way through a ch1 debounce
      pins_raw = 4'b1010;
      tick(4);
      rst_n = 1'b0;
      #1;
      chk("async_pins", pins_i, 0);
      chk("async_events", events, 0);
      chk("async_irq", irq, 0);
      tick(2);
      // resume from cleared state; ch3 rise masked
      rise_en = 4'b0111;
      rst_n = 1'b1;
      tick(lat - 1);
      chk("resume_pins_early", pins_i, 0);
      tick(1);
      chk("resume_pins", pins_i, 4'b1010);
      chk("resume_ev_early", events, 0);
      tick(1);
      chk("resume_events", events, 4'b0010);
      chk("resume_irq", irq, 1);
      if (DEB) begin
         // lowering the limit below a running count accepts on the next edge
         debounce_limit = 8'd200;
         pins_raw[2] = 1'b1;
         tick(52);
         chk("lim_pin2_hold", pins_i[2], 0);
         debounce_limit = 8'd10;
         tick(1);
         chk("lim_pin2_accept", pins_i[2], 1);
      end else begin
         // limit is ignored without debounce
         debounce_limit = 8'd255;
         pins_raw[2] = 1'b1;
         tick(2);
         chk("nodeb_pin2_early", pins_i[2], 0);
         tick(1);
         chk("nodeb_pin2", pins_i[2], 1);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
